merge2_arbiter: RTL
===================

# merge2_arbiter

Two-input round-robin merge node for the tree NoC. It is the upward-path counterpart of the routing decoder. The decoder splits one packet stream onto Out0/Out1 and announces the choice on S. This block accepts packets from two child links and serialises them onto one parent link, announcing the winning input on S before each packet. It sits between the RTL side of the channel interfaces (valid/ready per channel) and the 1-of-N send/receive converters. It buffers one packet per input.

## Interface
Parameters:
- `W`, 9, packet width. Bits [8:5] are the destination address and bits [4:0] are the payload. The block forwards packets unmodified.

Ports:
- `CLK`  in  1  clock; all state changes on its rising edge.
- `_RESET`  in  1  asynchronous, active-high reset. Asserting it (1) resets immediately.
- `in0_data`  in  W  packet from child 0.
- `in0_valid`  in  1  child 0 offers `in0_data`.
- `in0_ready`  out  1  buffer 0 empty; accept.
- `in1_data`  in  W  packet from child 1.
- `in1_valid`  in  1  child 1 offers `in1_data`.
- `in1_ready`  out  1  buffer 1 empty; accept.
- `s_data`  out  1  index of the winning input.
- `s_valid`  out  1  `s_data` offered.
- `s_ready`  in  1  S consumer accepts.
- `out_data`  out  W  forwarded packet.
- `out_valid`  out  1  `out_data` offered.
- `out_ready`  in  1  parent accepts.

## Operation
Handshakes:
- A transfer occurs on a rising edge where valid=1 and ready=1.
- Once a sender raises valid, it holds valid and data stable until the transfer.

Input buffers:
- There is one W-bit buffer and one `full` flag per input.
- `inN_ready` = ~fullN.
- On an `inN` transfer, the buffer captures `inN_data` and fullN becomes 1.
- fullN clears only on the `out` transfer of that buffer's packet.
- While a buffer is full, its input sees ready=0. The other input keeps accepting independently.

State machine, states IDLE, SEND_S and SEND_OUT; registers `grant` (1b) and `last` (1b):
- IDLE: if neither buffer is full, stay in IDLE. Otherwise choose the winner:
  - if only one buffer is full, that buffer wins;
  - if both are full, the winner is ~`last`.
  - Latch the winner into `grant` and go to SEND_S.
- SEND_S:
  - `s_valid`=1 and `s_data`=`grant`.
  - On `s_ready`, go to SEND_OUT.
- SEND_OUT:
  - `out_valid`=1 and `out_data`=buffer[`grant`].
  - On `out_ready`: clear full[`grant`], set `last`←`grant`, go to IDLE.
- Arbitration is decided only in IDLE. A packet that arrives on the other input during SEND_S or SEND_OUT does not pre-empt the current grant.
- An input transfer and an `out` transfer on the same edge cannot involve the same buffer, because that buffer's ready is 0. Transfers on the other buffer proceed normally on that edge.
- The S transfer always strictly precedes the corresponding Out transfer. Out is never offered before S completes.

Reset (async assert, sampled deassert):
- full0 = full1 = 0 and both buffers are cleared to 0.
- State = IDLE, `grant`=0, `last`=1, so input 0 wins the first tie.
- Outputs: `in0_ready`=`in1_ready`=1, `s_valid`=`out_valid`=0, `s_data`=0, `out_data`=0.
- Asserting reset mid-operation drops all buffered and in-flight packets. No partial S or Out transfer completes after reset.

## Timing
- All outputs are functions of registered state only. There are no combinational paths from input to output, including ready.
- Latency with ready held high:
  - input transfer at edge t: fullN=1 after t;
  - IDLE→SEND_S at edge t+1, so `s_valid`=1 during cycle t+1;
  - S transfer at t+2, so `out_valid`=1 during cycle t+2;
  - Out transfer at t+3, so `inN_ready`=1 again after t+3.
- Peak throughput is one packet per 3 cycles.
- Back-pressure (`s_ready` or `out_ready` low) holds the state. `s_data` or `out_data` stay stable, and the granted buffer's ready stays 0.
- Sustained contention alternates grants strictly 0,1,0,1…

## Test plan
- Single packet on in0, `in0_data`=9'h1A5 at edge 0, all readys high: `s_valid`=1 with `s_data`=0 during cycle 1; `out_valid`=1 with `out_data`=9'h1A5 during cycle 2; `in0_ready`=1 after edge 3.
- Simultaneous offer of in0=9'h0F0 and in1=9'h10F after reset: S=0 then Out=9'h0F0, followed by S=1 then Out=9'h10F. in1 is held (`in1_ready`=0) until its own Out transfer.
- Back-pressure: one packet in1=9'h055 with `out_ready` held 0 for 5 cycles in SEND_OUT: `out_valid` stays 1 and `out_data`=9'h055 stays stable; `in1_ready`=0 throughout; in0 can still load one packet (9'h1FF). After `out_ready` rises, 9'h055 is sent, then 9'h1FF.
- Fairness: both inputs offer packets continuously, 8 packets each, with distinct values. The Out order alternates 0,1,0,1…; the S sequence matches; no packet is lost or duplicated.
- S stall: `s_ready`=0 for 4 cycles. `out_valid` stays 0 until the S transfer, then rises the next cycle.
- Reset mid-SEND_OUT with both buffers full: during reset `out_valid`=`s_valid`=0 and both readys=1. After reset deasserts, no output until a new input transfer, and the first tie is won by in0.

Source files
------------

// File: rtl/merge2_arbiter.sv
// Two-input round-robin merge node: buffers one packet per child link and
// serialises them onto the parent link, announcing the winning input on S first.
module merge2_arbiter #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_S   = 2'd1,
    SEND_OUT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [1:0]     full_q, full_d;
  logic [W-1:0]   buf0_q, buf0_d;
  logic [W-1:0]   buf1_q, buf1_d;
  logic           in0_ready_q, in0_ready_d;
  logic           in1_ready_q, in1_ready_d;
  logic           s_valid_q, s_valid_d;
  logic           s_data_q, s_data_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           in0_take, in1_take;

  // Next-state, buffer capture and output decode; outputs are taken from the
  // next state so every port is driven straight from a flop.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    full_d   = full_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    in0_take = in0_valid & ~full_q[0];
    in1_take = in1_valid & ~full_q[1];

    if (in0_take) begin
      full_d[0] = 1'b1;
      buf0_d    = in0_data;
    end else begin
      buf0_d    = buf0_q;
    end
    if (in1_take) begin
      full_d[1] = 1'b1;
      buf1_d    = in1_data;
    end else begin
      buf1_d    = buf1_q;
    end

    case (state_q)
      IDLE: begin
        // A lone full buffer wins outright; a tie goes to the one not served last.
        if (full_q != 2'b00) begin
          grant_d = (full_q == 2'b11) ? ~last_q : full_q[1];
          state_d = SEND_S;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_S: begin
        state_d = s_ready ? SEND_OUT : SEND_S;
      end
      SEND_OUT: begin
        if (out_ready) begin
          full_d[grant_q] = 1'b0;
          last_d          = grant_q;
          state_d         = IDLE;
        end else begin
          state_d         = SEND_OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in0_ready_d = ~full_d[0];
    in1_ready_d = ~full_d[1];
    s_valid_d   = (state_d == SEND_S);
    out_valid_d = (state_d == SEND_OUT);
    s_data_d    = (state_d == SEND_S) ? grant_d : s_data_q;
    out_data_d  = (state_d == SEND_OUT) ? (grant_d ? buf1_d : buf0_d) : out_data_q;
  end

  // State, buffers and registered outputs; reset drops everything in flight.
  always_ff @(posedge CLK or posedge _RESET) begin
    if (_RESET) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      full_q      <= 2'b00;
      buf0_q      <= {W{1'b0}};
      buf1_q      <= {W{1'b0}};
      in0_ready_q <= 1'b1;
      in1_ready_q <= 1'b1;
      s_valid_q   <= 1'b0;
      s_data_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      full_q      <= full_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      in0_ready_q <= in0_ready_d;
      in1_ready_q <= in1_ready_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in0_ready = in0_ready_q;
  assign in1_ready = in1_ready_q;
  assign s_valid   = s_valid_q;
  assign s_data    = s_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
